// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, fn3 codes and size helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD0W = 3'd2,
        ST_RD1  = 3'd3,
        ST_RD1W = 3'd4,
        ST_WR   = 3'd5,
        ST_RESP = 3'd6
    } lsu_state_t;

    localparam logic [31:0] DMEM_BASE_DEF  = 32'h8000_2000;
    localparam int unsigned DMEM_BYTES_DEF = 32768;

    localparam logic [2:0] FN3_B  = 3'b000;
    localparam logic [2:0] FN3_H  = 3'b001;
    localparam logic [2:0] FN3_W  = 3'b010;
    localparam logic [2:0] FN3_BU = 3'b100;
    localparam logic [2:0] FN3_HU = 3'b101;

    // Access width in bytes; the unused encoding 2'b11 is rejected by fn3_legal
    function automatic logic [2:0] size_bytes(input logic [2:0] fn3);
        case (fn3[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Stores only have signed-looking codes; unsigned variants exist for loads alone
    function automatic logic fn3_legal(input logic we, input logic [2:0] fn3);
        if (we)
            fn3_legal = (fn3 == FN3_B) || (fn3 == FN3_H) || (fn3 == FN3_W);
        else
            fn3_legal = (fn3 == FN3_B) || (fn3 == FN3_H) || (fn3 == FN3_W) ||
                        (fn3 == FN3_BU) || (fn3 == FN3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - merges two load words, shifts to the byte offset and extends per fn3
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [1:0]  off,
    input  logic [2:0]  fn3,
    output logic [31:0] rdata
);

    logic [63:0] merged;
    logic [31:0] shifted;

    // Aligned loads arrive already formatted with off=0, so re-extension is a no-op for them
    always_comb begin
        merged  = {w1, w0};
        shifted = 32'(merged >> {off, 3'b000});
        case (fn3)
            FN3_B:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            FN3_H:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            FN3_BU:  rdata = {24'd0, shifted[7:0]};
            FN3_HU:  rdata = {16'd0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between execute stage and DataMem
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE   = DMEM_BASE_DEF,
    parameter int unsigned DMEM_BYTES  = DMEM_BYTES_DEF,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_fn3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    output logic [2:0]  mem_fn3,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_next;
    logic [1:0]  k, k_next;
    logic [31:0] addr_q, wdata_q, w0_q, rdata_q;
    logic [2:0]  fn3_q;
    logic        mis_q, err_q;

    logic [2:0]  req_n;
    logic        mis_now, bad_now, in_range;
    logic [32:0] req_end, dmem_limit;
    logic [1:0]  last_k;
    logic        accept;

    logic [31:0] mem_addr_next, mem_wdata_next;
    logic [2:0]  mem_fn3_next;
    logic        mem_wr_en_next;

    logic [31:0] align_w0, align_rdata;
    logic [1:0]  align_off;

    // Request classification: size, misalignment, window check with 33-bit arithmetic so nothing wraps
    always_comb begin
        req_n      = size_bytes(req_fn3);
        mis_now    = (req_addr[1:0] & 2'(req_n - 3'd1)) != 2'b00;
        req_end    = {1'b0, req_addr} + 33'(req_n);
        dmem_limit = {1'b0, DMEM_BASE} + 33'(DMEM_BYTES);
        in_range   = ({1'b0, req_addr} >= {1'b0, DMEM_BASE}) && (req_end <= dmem_limit);
        bad_now    = !fn3_legal(req_we, req_fn3) || !in_range || (mis_now && !MISALIGN_EN);
        last_k     = 2'(size_bytes(fn3_q) - 3'd1);
        accept     = (state == ST_IDLE) && req_valid;
    end

    // State register; reset also aborts any op in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            k     <= 2'd0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

    // Next-state and split-store byte counter
    always_comb begin
        state_next = state;
        k_next     = k;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    k_next = 2'd0;
                    if (bad_now)     state_next = ST_RESP;
                    else if (req_we) state_next = ST_WR;
                    else             state_next = ST_RD0;
                end
            end
            ST_RD0:  state_next = ST_RD0W;
            ST_RD0W: state_next = mis_q ? ST_RD1 : ST_RESP;
            ST_RD1:  state_next = ST_RD1W;
            ST_RD1W: state_next = ST_RESP;
            ST_WR: begin
                if (mis_q && (k != last_k)) begin
                    state_next = ST_WR;
                    k_next     = k + 2'd1;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: next DataMem port values keyed on the state being entered, plus pipeline-side response
    always_comb begin
        mem_addr_next  = mem_addr;
        mem_fn3_next   = mem_fn3;
        mem_wdata_next = mem_wdata;
        mem_wr_en_next = 1'b0;
        case (state_next)
            ST_RD0: begin
                mem_addr_next = mis_now ? {req_addr[31:2], 2'b00} : req_addr;
                mem_fn3_next  = mis_now ? FN3_W : req_fn3;
            end
            ST_RD1: begin
                mem_addr_next = {addr_q[31:2], 2'b00} + 32'd4;
                mem_fn3_next  = FN3_W;
            end
            ST_WR: begin
                mem_wr_en_next = 1'b1;
                if (state == ST_IDLE) begin
                    mem_addr_next  = req_addr;
                    mem_fn3_next   = mis_now ? FN3_B : req_fn3;
                    mem_wdata_next = mis_now ? {24'd0, req_wdata[7:0]} : req_wdata;
                end else begin
                    mem_addr_next  = addr_q + {30'd0, k_next};
                    mem_fn3_next   = FN3_B;
                    mem_wdata_next = {24'd0, wdata_q[{k_next, 3'b000} +: 8]};
                end
            end
            default: ;
        endcase
        req_ready  = rst_n && (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) && err_q;
        resp_rdata = (state == ST_RESP) ? rdata_q : 32'd0;
    end

    // Registered DataMem port keeps addr/fn3 stable from issue through wait cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= DMEM_BASE;
            mem_fn3   <= FN3_W;
            mem_wdata <= 32'd0;
            mem_wr_en <= 1'b0;
        end else begin
            mem_addr  <= mem_addr_next;
            mem_fn3   <= mem_fn3_next;
            mem_wdata <= mem_wdata_next;
            mem_wr_en <= mem_wr_en_next;
        end
    end

    assign align_w0  = mis_q ? w0_q : mem_rdata;
    assign align_off = mis_q ? addr_q[1:0] : 2'b00;

    lsu_align u_align (
        .w0    (align_w0),
        .w1    (mem_rdata),
        .off   (align_off),
        .fn3   (fn3_q),
        .rdata (align_rdata)
    );

    // Request capture on accept, first-word hold for split loads, final load result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            fn3_q   <= FN3_W;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            w0_q    <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                fn3_q   <= req_fn3;
                mis_q   <= mis_now;
                err_q   <= bad_now;
                rdata_q <= 32'd0;
            end
            if (state == ST_RD0W && mis_q)
                w0_q <= mem_rdata;
            if ((state == ST_RD0W && !mis_q) || state == ST_RD1W)
                rdata_q <= align_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl with a DataMem model
module tb_lsu_ctrl;

    localparam logic [31:0] BASE = 32'h8000_2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_fn3 = 3'b010;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, mem_wr_en;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_fn3;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [2:0]  b_req_fn3 = 3'b010;
    logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_wr_en;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
    logic [2:0]  b_mem_fn3;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  dmem [0:32767];
    logic [31:0] rd_word_q = 32'd0;
    logic [1:0]  rd_off_q = 2'd0;
    int          wr_count = 0, b_wr_count = 0, resp_count = 0;
    logic [31:0] wlog_addr [0:15];
    logic [31:0] wlog_data [0:15];
    logic [2:0]  wlog_fn3  [0:15];
    logic [31:0] tr_addr [0:31];
    logic [2:0]  tr_fn3  [0:31];

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_fn3(req_fn3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_fn3(mem_fn3), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.MISALIGN_EN(1'b0)) dut_nomis (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_fn3(b_req_fn3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr_en(b_mem_wr_en),
        .mem_fn3(b_mem_fn3), .mem_rdata(32'd0)
    );

    function automatic logic [31:0] dm_fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (f)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    assign mem_rdata = dm_fmt(rd_word_q, rd_off_q, mem_fn3);

    // DataMem model: registered word read, byte-lane writes, plus write/response logging
    always @(posedge clk) begin
        int o, a;
        o = int'(mem_addr - BASE);
        a = o & 32'h7FFC;
        rd_word_q <= {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
        rd_off_q  <= mem_addr[1:0];
        if (resp_valid) resp_count++;
        if (b_mem_wr_en) b_wr_count++;
        if (mem_wr_en) begin
            if (wr_count < 16) begin
                wlog_addr[wr_count] = mem_addr;
                wlog_data[wr_count] = mem_wdata;
                wlog_fn3[wr_count]  = mem_fn3;
            end
            wr_count++;
            if ((mem_addr - BASE) < 32'd32768) begin
                dmem[o] = mem_wdata[7:0];
                if (mem_fn3[1:0] != 2'b00 && o + 1 < 32768) dmem[o+1] = mem_wdata[15:8];
                if (mem_fn3[1:0] == 2'b10 && o + 3 < 32768) begin
                    dmem[o+2] = mem_wdata[23:16];
                    dmem[o+3] = mem_wdata[31:24];
                end
            end
        end
    end

    task automatic do_op(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_fn3 = f; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_fn3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
        lat = -1; rd = 32'hX; er = 1'bX;
        for (int c = 1; c <= 20; c++) begin
            tr_addr[c] = mem_addr;
            tr_fn3[c]  = mem_fn3;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_fn3", {29'd0, mem_fn3}, 32'd2);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic test_load_aligned();
        int lat; logic [31:0] rd; logic er;
        {dmem[7], dmem[6], dmem[5], dmem[4]} = 32'hDEAD_BEEF;
        do_op(1'b0, 3'b010, 32'h8000_2004, 32'd0, lat, rd, er);
        chk("lw_latency", 32'(lat), 32'd3);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_err", {31'd0, er}, 32'd0);
        chk("lw_issue_addr", tr_addr[1], 32'h8000_2004);
        chk("lw_wait_addr", tr_addr[2], 32'h8000_2004);
        chk("lw_wait_fn3", {29'd0, tr_fn3[2]}, 32'd2);
        do_op(1'b0, 3'b000, 32'h8000_2005, 32'd0, lat, rd, er);
        chk("lb_rdata", rd, 32'hFFFF_FFBE);
        chk("lb_wait_fn3", {29'd0, tr_fn3[2]}, 32'd0);
        do_op(1'b0, 3'b100, 32'h8000_2005, 32'd0, lat, rd, er);
        chk("lbu_rdata", rd, 32'h0000_00BE);
    endtask

    task automatic test_load_misaligned();
        int lat; logic [31:0] rd; logic er;
        {dmem[3], dmem[2], dmem[1], dmem[0]} = 32'h8003_0201;
        {dmem[7], dmem[6], dmem[5], dmem[4]} = 32'h0807_06FF;
        do_op(1'b0, 3'b001, 32'h8000_2003, 32'd0, lat, rd, er);
        chk("lh_mis_latency", 32'(lat), 32'd5);
        chk("lh_mis_rdata", rd, 32'hFFFF_FF80);
        chk("lh_mis_rd0_addr", tr_addr[1], 32'h8000_2000);
        chk("lh_mis_rd0w_addr", tr_addr[2], 32'h8000_2000);
        chk("lh_mis_rd1_addr", tr_addr[3], 32'h8000_2004);
        chk("lh_mis_rd1w_addr", tr_addr[4], 32'h8000_2004);
        chk("lh_mis_rd0_fn3", {29'd0, tr_fn3[1]}, 32'd2);
        do_op(1'b0, 3'b010, 32'h8000_2002, 32'd0, lat, rd, er);
        chk("lw_mis_rdata", rd, 32'h06FF_8003);
        do_op(1'b0, 3'b101, 32'h8000_2003, 32'd0, lat, rd, er);
        chk("lhu_mis_rdata", rd, 32'h0000_FF80);
    endtask

    task automatic test_store();
        int lat, w0; logic [31:0] rd; logic er;
        for (int i = 0; i < 12; i++) dmem[i] = 8'h00;
        w0 = wr_count;
        do_op(1'b1, 3'b010, 32'h8000_2001, 32'h1122_3344, lat, rd, er);
        chk("sw_mis_writes", 32'(wr_count - w0), 32'd4);
        chk("sw_mis_latency", 32'(lat), 32'd5);
        chk("sw_mis_rdata", rd, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("sw_mis_wr_addr", wlog_addr[w0+k], 32'h8000_2001 + 32'(k));
            chk("sw_mis_wr_byte", {24'd0, wlog_data[w0+k][7:0]}, 32'(8'h44 - 8'(k * 8'h11)));
            chk("sw_mis_wr_fn3", {29'd0, wlog_fn3[w0+k]}, 32'd0);
        end
        do_op(1'b0, 3'b010, 32'h8000_2000, 32'd0, lat, rd, er);
        chk("sw_mis_rb_w0", rd, 32'h2233_4400);
        do_op(1'b0, 3'b010, 32'h8000_2004, 32'd0, lat, rd, er);
        chk("sw_mis_rb_w1", rd, 32'h0000_0011);
        w0 = wr_count;
        do_op(1'b1, 3'b010, 32'h8000_2008, 32'hCAFE_F00D, lat, rd, er);
        chk("sw_al_latency", 32'(lat), 32'd2);
        chk("sw_al_writes", 32'(wr_count - w0), 32'd1);
        do_op(1'b0, 3'b010, 32'h8000_2008, 32'd0, lat, rd, er);
        chk("sw_al_rb", rd, 32'hCAFE_F00D);
    endtask

    task automatic test_errors();
        int lat, w0; logic [31:0] rd; logic er;
        {dmem[32767], dmem[32766], dmem[32765], dmem[32764]} = 32'h1234_5678;
        w0 = wr_count;
        do_op(1'b0, 3'b100, 32'h8000_1FFF, 32'd0, lat, rd, er);
        chk("err_below_lat", 32'(lat), 32'd1);
        chk("err_below_err", {31'd0, er}, 32'd1);
        chk("err_below_rdata", rd, 32'd0);
        do_op(1'b1, 3'b010, 32'h8000_9FFE, 32'h5555_AAAA, lat, rd, er);
        chk("err_above_err", {31'd0, er}, 32'd1);
        chk("err_above_rdata", rd, 32'd0);
        do_op(1'b0, 3'b011, 32'h8000_2000, 32'd0, lat, rd, er);
        chk("err_fn3_err", {31'd0, er}, 32'd1);
        do_op(1'b1, 3'b100, 32'h8000_2000, 32'd0, lat, rd, er);
        chk("err_sfn3_err", {31'd0, er}, 32'd1);
        chk("err_no_writes", 32'(wr_count - w0), 32'd0);
        do_op(1'b0, 3'b010, 32'h8000_9FFC, 32'd0, lat, rd, er);
        chk("top_word_err", {31'd0, er}, 32'd0);
        chk("top_word_rdata", rd, 32'h1234_5678);
    endtask

    task automatic test_misalign_disabled();
        int lat;
        lat = -1;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_fn3 = 3'b001;
        b_req_addr = 32'h8000_2001; b_req_wdata = 32'h0000_BEEF;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (b_resp_valid) begin
                lat = c;
                chk("nomis_err", {31'd0, b_resp_err}, 32'd1);
                chk("nomis_rdata", b_resp_rdata, 32'd0);
                break;
            end
            @(negedge clk);
        end
        chk("nomis_latency", 32'(lat), 32'd1);
        chk("nomis_writes", 32'(b_wr_count), 32'd0);
    endtask

    task automatic test_reset_mid_store();
        int w0, r0;
        for (int i = 16; i < 24; i++) dmem[i] = 8'h00;
        w0 = wr_count; r0 = resp_count;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_fn3 = 3'b010; req_addr = 32'h8000_2011; req_wdata = 32'hAABB_CCDD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_first_sb_wr", {31'd0, mem_wr_en}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_wr_dropped", {31'd0, mem_wr_en}, 32'd0);
        chk("mid_ready_in_rst", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("mid_writes", 32'(wr_count - w0), 32'd1);
        chk("mid_no_resp", 32'(resp_count - r0), 32'd0);
        chk("mid_byte0", {24'd0, dmem[17]}, 32'h0000_00DD);
        chk("mid_byte1", {24'd0, dmem[18]}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) dmem[i] = 8'h00;
        test_reset();
        test_load_aligned();
        test_load_misaligned();
        test_store();
        test_errors();
        test_misalign_disabled();
        test_reset_mid_store();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
